// File: rtl/ps2_rx.sv
// ps2_rx: receives PS/2 keyboard frames (start, 8 data bits LSB-first, odd parity, stop).
// Both pins are synchronized. The PS/2 clock is glitch-filtered, and its falling edges
// drive a small frame FSM.
//
// Ports
//   clk        : system clock (rising edge)
//   rst        : asynchronous active-high reset
//   kbdclk     : PS/2 clock pin (asynchronous)
//   kbddat     : PS/2 data pin (asynchronous)
//   keycode    : last correctly received byte, held as a level
//   valid      : one-cycle pulse when keycode is updated
//   parity_err : one-cycle pulse for a frame with bad parity
//   frame_err  : one-cycle pulse for a bad stop bit or a timeout abort
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a clock fall)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | checking odd parity over data + parity bit
// STOP   | checking the stop bit and reporting the result
module ps2_rx #(
    parameter int FILT_LEN = 8,
    parameter int TIMEOUT  = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbdclk,
    input  logic       kbddat,
    output logic [7:0] keycode,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [FW-1:0] filt_cnt_q;
    logic          fclk_q, fclk_prev_q;
    logic          fall_d;
    state_t        state_q;
    logic [7:0]    shift_q, keycode_q;
    logic [2:0]    bit_cnt_q;
    logic          parity_ok_q;
    logic [TW-1:0] to_cnt_q;
    logic          valid_q, parity_err_q, frame_err_q;

    // The synchronizers reset to 1, which is the idle level of both pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= kbdclk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= kbddat;
            dat_s2_q <= dat_s1_q;
        end
    end

    // The filtered clock flips on the FILT_LEN-th consecutive sample at the new level.
    // Any sample back at the current level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt_q  <= '0;
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
        end else begin
            fclk_prev_q <= fclk_q;
            if (clk_s2_q == fclk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
                filt_cnt_q <= '0;
                fclk_q     <= clk_s2_q;
            end else begin
                filt_cnt_q <= filt_cnt_q + FW'(1);
            end
        end
    end

    assign fall_d = fclk_prev_q & ~fclk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            parity_ok_q  <= 1'b0;
            to_cnt_q     <= '0;
            keycode_q    <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (state_q != IDLE && to_cnt_q == TW'(TIMEOUT)) begin
                // The keyboard stalled mid-frame, so the partial byte is dropped.
                state_q     <= IDLE;
                to_cnt_q    <= '0;
                shift_q     <= '0;
                bit_cnt_q   <= '0;
                frame_err_q <= 1'b1;
            end else begin
                if (state_q == IDLE || fall_d)
                    to_cnt_q <= '0;
                else
                    to_cnt_q <= to_cnt_q + TW'(1);

                if (fall_d) begin
                    case (state_q)
                        IDLE: begin
                            if (!dat_s2_q) begin
                                state_q   <= DATA;
                                bit_cnt_q <= '0;
                            end
                        end
                        DATA: begin
                            shift_q   <= {dat_s2_q, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7)
                                state_q <= PARITY;
                        end
                        PARITY: begin
                            parity_ok_q <= ^{shift_q, dat_s2_q};
                            state_q     <= STOP;
                        end
                        STOP: begin
                            if (!dat_s2_q) begin
                                frame_err_q <= 1'b1;
                            end else if (parity_ok_q) begin
                                keycode_q <= shift_q;
                                valid_q   <= 1'b1;
                            end else begin
                                parity_err_q <= 1'b1;
                            end
                            state_q <= IDLE;
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign keycode    = keycode_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: runs directed and randomized PS/2 frames against ps2_rx.
// The expected keycode and the expected count of each pulse type come from
// the PS/2 frame rules applied to each byte.
module tb_ps2_rx;

    localparam int FILT_LEN = 4;
    localparam int TIMEOUT  = 2000;
    localparam int HALF     = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbdclk = 1'b1;
    logic       kbddat = 1'b1;
    logic [7:0] keycode;
    logic       valid, parity_err, frame_err;

    ps2_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .kbdclk     (kbdclk),
        .kbddat     (kbddat),
        .keycode    (keycode),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0, bad = 0;
    int n_v = 0, n_p = 0, n_f = 0;
    int exp_v = 0, exp_p = 0, exp_f = 0;
    logic [7:0] exp_key = 8'h00;
    int last_pulse = 0;
    int t_fall = 0;
    logic any_prev = 1'b0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        int np;
        np = int'(valid) + int'(parity_err) + int'(frame_err);
        if (np > 0) begin
            check_eq("onehot", np, 1);
            check_eq("width", int'(any_prev), 0);
            last_pulse = cyc;
        end
        n_v += int'(valid);
        n_p += int'(parity_err);
        n_f += int'(frame_err);
        any_prev = (np > 0);
    end

    task automatic ps2_bit(input logic b);
        kbddat = b;
        repeat (HALF) @(negedge clk);
        kbdclk = 1'b0;
        t_fall = cyc;
        repeat (HALF) @(negedge clk);
        kbdclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop, input int nbits);
        logic [10:0] f;
        f = {stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        kbddat = 1'b1;
    endtask

    // Result of a complete frame, taken straight from the frame rules.
    task automatic model_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        int ones;
        ones = $countones(d) + int'((~^d) ^ bad_par);
        if (!stop) exp_f++;
        else if (ones % 2 == 1) begin
            exp_v++;
            exp_key = d;
        end else exp_p++;
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_valid"}, n_v, exp_v);
        check_eq({tag, "_perr"}, n_p, exp_p);
        check_eq({tag, "_ferr"}, n_f, exp_f);
        check_eq({tag, "_key"}, int'(keycode), int'(exp_key));
    endtask

    task automatic frame_and_check(input string tag, input logic [7:0] d, input logic bad_par, input logic stop);
        model_frame(d, bad_par, stop);
        send_frame(d, bad_par, stop, 11);
        repeat (30) @(negedge clk);
        check_counts(tag);
        // 2 sync flops, FILT_LEN filter samples, then one registered cycle
        check_eq({tag, "_lat"}, last_pulse - t_fall, FILT_LEN + 3);
    endtask

    task automatic glitch(input int len);
        kbddat = 1'b0;
        kbdclk = 1'b0;
        repeat (len) @(negedge clk);
        kbdclk = 1'b1;
        repeat (HALF) @(negedge clk);
        kbddat = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_key", int'(keycode), 0);
        check_eq("rst_valid", int'(valid), 0);
        check_eq("rst_perr", int'(parity_err), 0);
        check_eq("rst_ferr", int'(frame_err), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        frame_and_check("f1c", 8'h1C, 1'b0, 1'b1);
        frame_and_check("ff0", 8'hF0, 1'b0, 1'b1);
        frame_and_check("f32", 8'h32, 1'b0, 1'b1);
        frame_and_check("badpar", 8'h32, 1'b1, 1'b1);
        exp_key = 8'h1C;
        model_frame(8'h1C, 1'b0, 1'b1);
        exp_v--;
        frame_and_check("good1c", 8'h1C, 1'b0, 1'b1);
        frame_and_check("badpar32", 8'h32, 1'b1, 1'b1);

        // partial frame: start bit + 4 data bits, then the keyboard goes silent
        send_frame(8'h55, 1'b0, 1'b1, 5);
        repeat (1900) @(negedge clk);
        check_counts("to_early");
        repeat (300) @(negedge clk);
        exp_f++;
        check_counts("timeout");
        frame_and_check("f21", 8'h21, 1'b0, 1'b1);

        glitch(2);
        check_counts("glitch");
        frame_and_check("badstop", 8'h24, 1'b0, 1'b0);

        // reset in the middle of a frame: start bit + 5 data bits
        send_frame(8'h6A, 1'b0, 1'b1, 6);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("mid_rst_key", int'(keycode), 0);
        check_eq("mid_rst_out", int'(valid) + int'(parity_err) + int'(frame_err), 0);
        rst = 1'b0;
        exp_key = 8'h00;
        repeat (50) @(negedge clk);
        check_counts("after_rst");
        frame_and_check("f2b", 8'h2B, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            logic bp, st;
            if ($urandom_range(0, 2) == 0) glitch($urandom_range(1, FILT_LEN - 1));
            d  = 8'($urandom);
            bp = ($urandom_range(0, 4) == 0);
            st = ($urandom_range(0, 5) != 0);
            frame_and_check("rand", d, bp, st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
